// File: rtl/car_direction_detector.sv
`default_nettype none
// ============================================================================
// Module   : car_direction_detector
// Purpose  : Conditions two beam-break sensors (A outside, B inside) and
//            decodes the order in which they are blocked. Each complete pass
//            yields a single-cycle pulse: sum (entry) or res (exit). Illegal
//            sequences and stalled passes yield a single-cycle err pulse.
// Ports    : clk       - rising-edge clock
//            reset_n   - asynchronous active-low reset
//            sensor_a  - outer beam, 1 = blocked, asynchronous to clk
//            sensor_b  - inner beam, 1 = blocked, asynchronous to clk
//            sum       - one-cycle pulse on completed entry
//            res       - one-cycle pulse on completed exit
//            err       - one-cycle pulse on illegal transition or timeout
//            busy      - high whenever the FSM is not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module car_direction_detector #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic sum,
    output logic res,
    output logic err,
    output logic busy
);

    localparam int C_DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Acceptance happens on the edge where the count would become
    // DEBOUNCE_CYCLES, so compare against one less.
    localparam logic [C_DEB_W-1:0] C_DEB_LAST = C_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_IN_A       = 3'd1,
        S_IN_AB      = 3'd2,
        S_IN_B       = 3'd3,
        S_OUT_B      = 3'd4,
        S_OUT_AB     = 3'd5,
        S_OUT_A      = 3'd6,
        S_WAIT_CLEAR = 3'd7
    } state_t;

    // Bit 1 = sensor A, bit 0 = sensor B, matching the {a,b} decode order.
    logic [1:0] w_raw;
    logic [1:0] w_deb;

    assign w_raw = {sensor_a, sensor_b};

    // ------------------------------------------------------------------
    // Per-sensor 2-FF synchronizer followed by a debounce filter.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic               r_meta;
        logic               r_sync;
        logic               r_deb;
        logic [C_DEB_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_deb  <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_meta <= w_raw[gi];
                r_sync <= r_meta;
                if (r_sync == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_DEB_LAST) begin
                    r_deb <= r_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + C_DEB_W'(1);
                end
            end
        end

        assign w_deb[gi] = r_deb;
    end

    // ------------------------------------------------------------------
    // Direction FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next;
    logic [C_TMO_W-1:0] r_tmo;
    logic               r_sum;
    logic               r_res;
    logic               r_err;
    logic               r_busy;
    logic               w_sum;
    logic               w_res;
    logic               w_err;
    logic               w_active;

    // Timeout only runs while a pass is actually in progress.
    assign w_active = (r_state != S_IDLE) && (r_state != S_WAIT_CLEAR);

    always_comb begin
        w_next = r_state;
        w_sum  = 1'b0;
        w_res  = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (w_deb)
                    2'b10:   w_next = S_IN_A;
                    2'b01:   w_next = S_OUT_B;
                    2'b11: begin w_next = S_WAIT_CLEAR; w_err = 1'b1; end
                    default: ;
                endcase
            end
            S_IN_A: begin
                case (w_deb)
                    2'b11:   w_next = S_IN_AB;
                    2'b00:   w_next = S_IDLE;
                    2'b01: begin w_next = S_WAIT_CLEAR; w_err = 1'b1; end
                    default: ;
                endcase
            end
            S_IN_AB: begin
                case (w_deb)
                    2'b01:   w_next = S_IN_B;
                    2'b10:   w_next = S_IN_A;
                    2'b00: begin w_next = S_IDLE; w_err = 1'b1; end
                    default: ;
                endcase
            end
            S_IN_B: begin
                case (w_deb)
                    2'b00: begin w_next = S_IDLE; w_sum = 1'b1; end
                    2'b11:   w_next = S_IN_AB;
                    2'b10: begin w_next = S_WAIT_CLEAR; w_err = 1'b1; end
                    default: ;
                endcase
            end
            S_OUT_B: begin
                case (w_deb)
                    2'b11:   w_next = S_OUT_AB;
                    2'b00:   w_next = S_IDLE;
                    2'b10: begin w_next = S_WAIT_CLEAR; w_err = 1'b1; end
                    default: ;
                endcase
            end
            S_OUT_AB: begin
                case (w_deb)
                    2'b10:   w_next = S_OUT_A;
                    2'b01:   w_next = S_OUT_B;
                    2'b00: begin w_next = S_IDLE; w_err = 1'b1; end
                    default: ;
                endcase
            end
            S_OUT_A: begin
                case (w_deb)
                    2'b00: begin w_next = S_IDLE; w_res = 1'b1; end
                    2'b11:   w_next = S_OUT_AB;
                    2'b01: begin w_next = S_WAIT_CLEAR; w_err = 1'b1; end
                    default: ;
                endcase
            end
            S_WAIT_CLEAR: begin
                if (w_deb == 2'b00) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase

        // A pass that completes on the timeout cycle still counts; any other
        // outcome is replaced by the timeout.
        if (w_active && (r_tmo == C_TMO_LAST) && !w_sum && !w_res) begin
            w_next = S_WAIT_CLEAR;
            w_err  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
            r_sum   <= 1'b0;
            r_res   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sum   <= w_sum;
            r_res   <= w_res;
            r_err   <= w_err;
            r_busy  <= (w_next != S_IDLE);
            if (w_active) begin
                r_tmo <= r_tmo + C_TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign sum  = r_sum;
    assign res  = r_res;
    assign err  = r_err;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: doc/car_direction_detector.md
# car_direction_detector

Upstream stage of the parking up/down counter. It conditions two beam-break sensors, A on the outside and B on the inside, and decodes the order in which they are blocked. For each complete pass it emits one single-cycle `sum` pulse (entry) or `res` pulse (exit). These outputs connect directly to the counter's `sum`/`res` inputs, and at most one of them is high in any cycle.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a sensor level is accepted (≥1).
- `TIMEOUT_CYCLES`, default 1024: maximum cycles allowed for one pass sequence before it is abandoned (≥8).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sensor_a`  in  1  outer beam, 1 = blocked; asynchronous to `clk`.
- `sensor_b`  in  1  inner beam, 1 = blocked; asynchronous to `clk`.
- `sum`  out  1  one-cycle pulse on a completed entry.
- `res`  out  1  one-cycle pulse on a completed exit.
- `err`  out  1  one-cycle pulse on an illegal transition or a timeout.
- `busy`  out  1  level; high whenever the FSM is not in IDLE.

## Operation
- **Synchronizers:** each sensor passes through a 2-FF synchronizer, giving `a_s` and `b_s`.
- **Debounce, per sensor:**
  - A counter of width $clog2(DEBOUNCE_CYCLES+1) increments while the synchronized level differs from the debounced level.
  - It clears when the two are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- **FSM input:** the FSM acts on the 2-bit pair `{a_d,b_d}`. All outputs are registered.
- **FSM states:** IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLEAR.
- **Transitions** (input value → next state; any value not listed holds the current state):
  - IDLE: 10→IN_A; 01→OUT_B; 11→WAIT_CLEAR + err.
  - IN_A: 11→IN_AB; 00→IDLE (abort, no pulse); 01→WAIT_CLEAR + err.
  - IN_AB: 01→IN_B; 10→IN_A (vehicle backing out); 00→IDLE + err.
  - IN_B: 00→IDLE + `sum`; 11→IN_AB; 10→WAIT_CLEAR + err.
  - OUT_B: 11→OUT_AB; 00→IDLE (abort); 10→WAIT_CLEAR + err.
  - OUT_AB: 10→OUT_A; 01→OUT_B; 00→IDLE + err.
  - OUT_A: 00→IDLE + `res`; 11→OUT_AB; 01→WAIT_CLEAR + err.
  - WAIT_CLEAR: 00→IDLE; otherwise hold. No pulses are issued from this state.
- **Timeout:**
  - A timeout counter clears on every cycle spent in IDLE or WAIT_CLEAR and increments in all other states.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to WAIT_CLEAR and pulses `err`.
  - A valid completion (`sum`/`res`) in the same cycle takes priority over the timeout.
- **Exclusivity:** `sum`, `res` and `err` are mutually exclusive in every cycle.
- **Ownership:** saturation at 0/7 is the counter's job; this block never suppresses a pulse.

## Timing
- **Reset (`reset_n` low, asynchronous):**
  - FSM goes to IDLE.
  - Synchronizer flops, debounced levels and all counters go to 0.
  - `sum` = `res` = `err` = `busy` = 0.
- **Reset mid-operation:** any pass in progress is dropped and no pulse is emitted. After release the block starts from IDLE with debounced levels at 0.
  - If a sensor is still blocked at release, it is accepted after debounce like any new edge.
- **Latency** (edge 0 = first rising edge at which the synchronizer's first flop samples the new sensor level):
  - The debounced level changes at edge DEBOUNCE_CYCLES+1.
  - The FSM state change and any `sum`/`res`/`err` pulse are registered at edge DEBOUNCE_CYCLES+2.
  - Each pulse stays high for exactly one cycle.
- **`busy`** is registered together with the state and is high in the cycle after any transition out of IDLE.
- **Simultaneous changes:** when both debounced bits change in the same cycle, the pair is decoded as a single transition using the table above (e.g. IN_AB seeing 00).
- **Back-to-back passes:** a new pass may begin in the cycle immediately after the pulse. No dead time is required beyond debounce.

## Test plan
- **Entry pass:** with DEBOUNCE_CYCLES=4, drive AB 00→10→11→01→00, each held 20 cycles → exactly one `sum` pulse, 6 edges after the final edge is sampled; `res` = `err` = 0 throughout; `busy` falls in the same cycle the pulse rises.
- **Exit pass and counter chain:** drive AB 00→01→11→10→00 → one `res` pulse. Chain with the counter: 3 entries then 1 exit → count = 2.
- **Glitch rejection:** a 3-cycle pulse on `sensor_a` with DEBOUNCE_CYCLES=4 → no state change and `busy` stays 0. A 5-cycle pulse → `busy` goes to 1.
- **Abort and back-up:** 00→10→00 → no pulse, returns to IDLE. Sequence 10→11→10→11→01→00 → exactly one `sum`.
- **Illegal transition and timeout:**
  - 10→01 → one `err` pulse, state WAIT_CLEAR; a following 10 produces no pulse; returns to IDLE only after 00.
  - Holding 10 for TIMEOUT_CYCLES cycles → `err` pulse, then WAIT_CLEAR.
- **Reset mid-pass:** assert `reset_n`=0 asynchronously while in IN_B → all outputs 0 immediately. After release, drive 00 → no `sum` pulse.
